// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: word-addressed register port between a bus master and irq_ctrl.
// Signals: reg_req_i/reg_wr_en_i/reg_addr_i/reg_data_i (request), reg_data_o/reg_ack_o (response).
interface irq_ctrl_if;
    logic        reg_req_i;
    logic        reg_wr_en_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_data_i;
    logic [31:0] reg_data_o;
    logic        reg_ack_o;

    modport master (
        output reg_req_i,
        output reg_wr_en_i,
        output reg_addr_i,
        output reg_data_i,
        input  reg_data_o,
        input  reg_ack_o
    );

    modport slave (
        input  reg_req_i,
        input  reg_wr_en_i,
        input  reg_addr_i,
        input  reg_data_i,
        output reg_data_o,
        output reg_ack_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised external interrupt controller with claim/complete.
// Ports: clk, rst (sync, active-high), src_i[NUM_SRC], bus (irq_ctrl_if.slave),
//        irq_o, irq_id_o[4:0]. Define IRQ_CTRL_EDGE_EN for per-source edge mode.
module irq_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    irq_ctrl_if.slave          bus,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_in_service;
    logic [PRIO_W-1:0]  r_thresh;
    logic [PRIO_W-1:0]  r_prio [NUM_SRC];
    logic               r_irq;
    logic [4:0]         r_irq_id;
    logic               r_ack;
    logic [31:0]        r_rdata;
`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] r_edge;
    logic [NUM_SRC-1:0] r_src_qq;
`endif

    logic [5:0]         w_word;
    logic               w_rd;
    logic               w_wr;
    logic               w_claim;
    logic               w_cmpl;
    logic [NUM_SRC-1:0] w_prio_hit;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_isv_nxt;
    logic [4:0]         w_win_id;
    logic [PRIO_W-1:0]  w_win_prio;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_word   = bus.reg_addr_i[7:2];
    assign w_rd     = bus.reg_req_i & ~bus.reg_wr_en_i;
    assign w_wr     = bus.reg_req_i & bus.reg_wr_en_i;
    assign w_claim  = w_rd & (w_word == 6'd3);
    assign w_cmpl   = w_wr & (w_word == 6'd3);
    assign w_unused = ^{bus.reg_addr_i[1:0], bus.reg_data_i};

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_prio_hit[i] = (w_word == 6'(16 + i));
        end
    end

    // Edge-mode pending is sticky; a new rise in the claim cycle beats the clear.
    always_comb begin
        w_pend_nxt = r_src_q;
`ifdef IRQ_CTRL_EDGE_EN
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_edge[i]) begin
                w_pend_nxt[i] = r_pending[i];
                if (w_claim && r_irq_id == 5'(i + 1)) begin
                    w_pend_nxt[i] = 1'b0;
                end
                if (r_src_q[i] && !r_src_qq[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        w_isv_nxt = r_in_service;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_claim && r_irq_id == 5'(i + 1)) begin
                w_isv_nxt[i] = 1'b1;
            end
            if (w_cmpl && bus.reg_data_i[4:0] == 5'(i + 1)) begin
                w_isv_nxt[i] = 1'b0;
            end
        end
    end

    // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
    always_comb begin
        w_win_id   = '0;
        w_win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = r_pending[i] & r_enable[i] & ~r_in_service[i]
                      & (r_prio[i] > r_thresh);
            if (w_elig[i] && r_prio[i] > w_win_prio) begin
                w_win_prio = r_prio[i];
                w_win_id   = 5'(i + 1);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            6'd0: w_rdata = 32'(r_pending);
            6'd1: w_rdata = 32'(r_enable);
            6'd2: w_rdata = 32'(r_thresh);
            6'd3: w_rdata = 32'(r_irq_id);
`ifdef IRQ_CTRL_EDGE_EN
            6'd4: w_rdata = 32'(r_edge);
`endif
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_prio_hit[i]) begin
                        w_rdata = 32'(r_prio[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q      <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_in_service <= '0;
            r_thresh     <= '0;
            r_irq        <= 1'b0;
            r_irq_id     <= '0;
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
`ifdef IRQ_CTRL_EDGE_EN
            r_edge       <= '0;
            r_src_qq     <= '0;
`endif
        end else begin
            r_src_q      <= src_i;
            r_pending    <= w_pend_nxt;
            r_in_service <= w_isv_nxt;
            r_irq        <= (w_win_id != 5'd0);
            r_irq_id     <= w_win_id;
            r_ack        <= bus.reg_req_i;
            r_rdata      <= w_rd ? w_rdata : 32'd0;
`ifdef IRQ_CTRL_EDGE_EN
            r_src_qq     <= r_src_q;
`endif
            if (w_wr) begin
                case (w_word)
                    6'd1: r_enable <= bus.reg_data_i[NUM_SRC-1:0];
                    6'd2: r_thresh <= bus.reg_data_i[PRIO_W-1:0];
`ifdef IRQ_CTRL_EDGE_EN
                    6'd4: r_edge   <= bus.reg_data_i[NUM_SRC-1:0];
`endif
                    default: begin
                        for (int i = 0; i < NUM_SRC; i++) begin
                            if (w_prio_hit[i]) begin
                                r_prio[i] <= bus.reg_data_i[PRIO_W-1:0];
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign irq_o          = r_irq;
    assign irq_id_o       = r_irq_id;
    assign bus.reg_ack_o  = r_ack;
    assign bus.reg_data_o = r_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus randomized checks of irq_ctrl against a
// priority/threshold reference model; edge tests run when IRQ_CTRL_EDGE_EN is set.
module tb_irq_ctrl;
    localparam int N  = 8;
    localparam int PW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src;
    logic         irq;
    logic [4:0]   irq_id;

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .src_i    (src),
        .bus      (bus.slave),
        .irq_o    (irq),
        .irq_id_o (irq_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] m_en;
    logic [N-1:0] m_isv;
    int           m_thr;
    int           m_prio [N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.reg_req_i   = 1'b1;
        bus.reg_wr_en_i = 1'b1;
        bus.reg_addr_i  = a;
        bus.reg_data_i  = d;
        tick();
        chk("wr_ack", 32'(bus.reg_ack_o), 32'd1);
        bus.reg_req_i   = 1'b0;
        bus.reg_wr_en_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.reg_req_i   = 1'b1;
        bus.reg_wr_en_i = 1'b0;
        bus.reg_addr_i  = a;
        tick();
        chk("rd_ack", 32'(bus.reg_ack_o), 32'd1);
        d = bus.reg_data_o;
        bus.reg_req_i   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Winner from the rules: max priority over eligible level sources,
    // then the smallest ID holding that priority.
    function automatic int model_win(input logic [N-1:0] lvl);
        int best = 0;
        for (int i = 0; i < N; i++)
            if (lvl[i] && m_en[i] && !m_isv[i] && m_prio[i] > m_thr && m_prio[i] > best)
                best = m_prio[i];
        if (best == 0) return 0;
        for (int i = 0; i < N; i++)
            if (lvl[i] && m_en[i] && !m_isv[i] && m_prio[i] == best)
                return i + 1;
        return 0;
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] r;
        int          w;
        int          k;

        rst = 1'b1;
        src = '0;
        bus.reg_req_i   = 1'b0;
        bus.reg_wr_en_i = 1'b0;
        bus.reg_addr_i  = '0;
        bus.reg_data_i  = '0;
        ticks(2);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_ack", 32'(bus.reg_ack_o), 32'd0);
        chk("rst_data", bus.reg_data_o, 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("rst_pend", 8'h00, 0);
        rd_chk("rst_en", 8'h04, 0);
        rd_chk("rst_thr", 8'h08, 0);
        rd_chk("rst_claim", 8'h0C, 0);
        rd_chk("rst_edge", 8'h10, 0);
        rd_chk("unmapped14", 8'h14, 0);
        rd_chk("unmapped3c", 8'h3C, 0);
        for (int i = 0; i < N; i++) rd_chk("rst_prio", 8'(8'h40 + 4 * i), 0);
        rd_chk("unmapped60", 8'h60, 0);

        // Level source, 3-cycle latency, claim/complete
        wr(8'h48, 3);
        wr(8'h08, 1);
        wr(8'h04, 32'h04);
        tick();
        src[2] = 1'b1;
        ticks(2);
        chk("lat2_irq", 32'(irq), 32'd0);
        tick();
        chk("lat3_irq", 32'(irq), 32'd1);
        chk("lat3_id", 32'(irq_id), 32'd3);
        rd_chk("claim3", 8'h0C, 3);
        tick();
        chk("claimed_irq", 32'(irq), 32'd0);
        wr(8'h0C, 3);
        tick();
        chk("recomp_irq", 32'(irq), 32'd1);
        chk("recomp_id", 32'(irq_id), 32'd3);
        src = '0;
        ticks(4);
        chk("drop_irq", 32'(irq), 32'd0);

        // Priority ordering and tie-break
        wr(8'h44, 5);
        wr(8'h50, 5);
        wr(8'h58, 7);
        wr(8'h04, 32'h52);
        src = 8'h52;
        ticks(4);
        rd_chk("ord_7", 8'h0C, 7);
        tick();
        rd_chk("ord_2", 8'h0C, 2);
        tick();
        rd_chk("ord_5", 8'h0C, 5);
        tick();
        rd_chk("ord_0", 8'h0C, 0);
        tick();
        chk("ord_irq", 32'(irq), 32'd0);
        wr(8'h0C, 7);
        wr(8'h0C, 2);
        wr(8'h0C, 5);
        tick();
        chk("ord_back", 32'(irq_id), 32'd7);
        src = '0;
        wr(8'h04, 0);
        ticks(4);

        // Threshold boundary and ignored completes
        wr(8'h40, 2);
        wr(8'h08, 2);
        wr(8'h04, 1);
        src = 8'h01;
        ticks(4);
        chk("thr_eq_irq", 32'(irq), 32'd0);
        wr(8'h08, 1);
        tick();
        chk("thr_lt_id", 32'(irq_id), 32'd1);
        rd_chk("claim1", 8'h0C, 1);
        tick();
        chk("isv_irq", 32'(irq), 32'd0);
        wr(8'h0C, 0);
        tick();
        chk("cmp0_irq", 32'(irq), 32'd0);
        wr(8'h0C, 9);
        tick();
        chk("cmp9_irq", 32'(irq), 32'd0);
        wr(8'h0C, 2);
        tick();
        chk("cmp2_irq", 32'(irq), 32'd0);
        wr(8'h0C, 1);
        tick();
        chk("cmp1_id", 32'(irq_id), 32'd1);
        src = '0;
        ticks(4);

`ifdef IRQ_CTRL_EDGE_EN
        wr(8'h10, 1);
        rd_chk("edge_rb", 8'h10, 1);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        ticks(4);
        chk("edge_id", 32'(irq_id), 32'd1);
        rd_chk("edge_pend", 8'h00, 1);
        // Rise detected at the claim-ack edge: set beats clear
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        bus.reg_req_i   = 1'b1;
        bus.reg_wr_en_i = 1'b0;
        bus.reg_addr_i  = 8'h0C;
        tick();
        chk("edge_claim", bus.reg_data_o, 32'd1);
        bus.reg_req_i = 1'b0;
        ticks(3);
        rd_chk("edge_keep", 8'h00, 1);
        chk("edge_isv", 32'(irq), 32'd0);
        wr(8'h0C, 1);
        tick();
        chk("edge_again", 32'(irq_id), 32'd1);
        rd_chk("edge_clm2", 8'h0C, 1);
        wr(8'h0C, 1);
        wr(8'h10, 0);
        ticks(3);
        chk("edge_clr", 32'(irq), 32'd0);
        rd_chk("edge_pend0", 8'h00, 0);
`else
        wr(8'h10, 1);
        rd_chk("edge_absent", 8'h10, 0);
`endif

        // Randomized level traffic against the model
        m_isv = '0;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                d = $urandom;
                wr(8'(8'h40 + 4 * i), d);
                m_prio[i] = int'(d[PW-1:0]);
            end
            d = $urandom;
            wr(8'h04, d);
            m_en = d[N-1:0];
            d = $urandom;
            wr(8'h08, d);
            m_thr = int'(d[PW-1:0]);
            src = N'($urandom);
            ticks(4);
            rd_chk("rnd_en", 8'h04, 32'(m_en));
            rd_chk("rnd_pend", 8'h00, 32'(src));
            w = model_win(src);
            chk("rnd_irq", 32'(irq), 32'(w != 0));
            chk("rnd_id", 32'(irq_id), 32'(w));
            k = $urandom_range(0, 3);
            for (int c = 0; c < k; c++) begin
                w = model_win(src);
                rd(8'h0C, r);
                chk("rnd_claim", r, 32'(w));
                if (w != 0) m_isv[w-1] = 1'b1;
                tick();
                w = model_win(src);
                chk("rnd_next", 32'(irq_id), 32'(w));
            end
            d = $urandom_range(0, 31);
            wr(8'h0C, d);
            if (d >= 1 && d <= N) m_isv[d-1] = 1'b0;
            tick();
            w = model_win(src);
            chk("rnd_cmp", 32'(irq_id), 32'(w));
            for (int i = 0; i < N; i++)
                if (m_isv[i]) wr(8'h0C, 32'(i + 1));
            m_isv = '0;
        end

        // Reset during an access
        src = '1;
        wr(8'h04, 32'hFF);
        wr(8'h08, 0);
        wr(8'h40, 7);
        ticks(4);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        bus.reg_req_i   = 1'b1;
        bus.reg_wr_en_i = 1'b0;
        bus.reg_addr_i  = 8'h04;
        rst = 1'b1;
        src = '0;
        tick();
        chk("inflt_ack", 32'(bus.reg_ack_o), 32'd0);
        chk("inflt_data", bus.reg_data_o, 32'd0);
        chk("inflt_irq", 32'(irq), 32'd0);
        chk("inflt_id", 32'(irq_id), 32'd0);
        bus.reg_req_i = 1'b0;
        rst = 1'b0;
        tick();
        rd_chk("post_en", 8'h04, 0);
        rd_chk("post_thr", 8'h08, 0);
        rd_chk("post_pend", 8'h00, 0);
        rd_chk("post_prio0", 8'h40, 0);
        rd_chk("post_claim", 8'h0C, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised external interrupt controller between the SoC interrupt lines and the core's interrupt input. It latches up to NUM_SRC sources, arbitrates by programmable priority against a threshold, and drives one interrupt request plus winning ID. Software services interrupts through a claim/complete handshake on a word-addressed register port on the peripheral bus. It replaces the fixed 8-line, unprioritised interrupt input.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..31; source i has ID i+1, ID 0 means none
- PRIO_W, 3: priority width, 1..8; priority 0 means never eligible
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_i  in  NUM_SRC  interrupt lines, synchronous to clk
- reg_req_i  in  1  register access strobe, one cycle per access
- reg_wr_en_i  in  1  1 = write, 0 = read, qualified by reg_req_i
- reg_addr_i  in  8  byte address; bits [1:0] ignored
- reg_data_i  in  32  write data
- reg_data_o  out  32  read data, valid with reg_ack_o
- reg_ack_o  out  1  access done, one cycle after reg_req_i
- irq_o  out  1  interrupt request to core
- irq_id_o  out  5  ID of current winner, 0 when irq_o is low

## Operation
- Register map:
  - 0x00 PENDING (RO)
  - 0x04 ENABLE (RW)
  - 0x08 THRESHOLD (RW, low PRIO_W bits)
  - 0x0C CLAIM on read / COMPLETE on write
  - 0x10 EDGE (RW, macro only)
  - 0x40+4*i PRIO[i] (RW, low PRIO_W bits)
- Unmapped reads return 0 and unmapped writes are ignored. Bits at or above NUM_SRC read 0 and are not writable.
- src_i is registered once into src_q.
- Level source: pending[i] = src_q[i], recomputed every cycle.
- Edge source: pending[i] is set on a src_q 0->1 transition and cleared only by a claim of that ID.
- A source is eligible when pending, enabled, not in-service, and PRIO[i] > THRESHOLD.
- Winner: highest PRIO among eligible sources; ties go to the lowest ID. irq_o and irq_id_o are registered from the winner.
- CLAIM read returns the current registered irq_id_o.
  - If nonzero: set in_service[id-1]; for an edge source, clear pending.
  - If zero: no state change.
- COMPLETE write uses ID = reg_data_i[4:0] and clears in_service[ID-1]. It is ignored if ID is 0, greater than NUM_SRC, or not in service.
- Several sources may be in service at once; each is excluded from arbitration until its own complete.
- Reset value of all state and outputs is 0: pending, in_service, ENABLE, THRESHOLD, PRIO, EDGE, src_q, irq_o, irq_id_o, reg_ack_o, reg_data_o.

## Timing
- Source rising in cycle 0:
  - src_q is set at edge 1.
  - pending is set at edge 2.
  - irq_o / irq_id_o are valid after edge 3.
  - Latency is 3 cycles.
- Register access: reg_req_i in cycle N gives reg_ack_o and reg_data_o in cycle N+1. Only one access is outstanding; a request during ack is accepted as a new access.
- Register writes take effect at the acking edge. Arbitration sees the new value one cycle later.
- CLAIM side effects happen at the acking edge. irq_o drops, or moves to the next winner, on the following cycle.
- Claim and a new edge on the same edge source in the same cycle: set wins, so pending stays 1 (the new edge is retained). The source stays excluded while in service.
- COMPLETE and a claim in the same cycle are only possible via separate accesses, so they cannot coincide.
- rst asserted mid-claim clears all state at that edge. No ack is produced for an access in flight.

## Configuration
- IRQ_CTRL_EDGE_EN defined:
  - The EDGE register exists; bit i = 1 selects edge mode for source i.
  - Edge detect and latched pending are implemented.
- IRQ_CTRL_EDGE_EN undefined:
  - All sources are level-only and no edge logic is built.
  - Address 0x10 reads 0 and writes are ignored.

## Test plan
- Reset, then read every register → all 0; irq_o=0; irq_id_o=0.
- PRIO[2]=3, THRESHOLD=1, ENABLE=0x04, pulse src_i[2] level-high → irq_o=1 and irq_id_o=3 exactly 3 cycles after the rise; CLAIM returns 3; irq_o=0 next cycle; COMPLETE 3 with src still high → irq_o=1 again.
- PRIO[1]=5, PRIO[4]=5, PRIO[6]=7, all enabled and asserted → IDs claimed in order 7, 2, 5, then CLAIM returns 0 with no state change.
- PRIO[0]=2, THRESHOLD=2 → no irq; set THRESHOLD=1 → irq_id_o=1.
- With IRQ_CTRL_EDGE_EN: EDGE=0x01, one-cycle pulse on src_i[0] → pending latched; second pulse in the CLAIM-ack cycle → PENDING bit0 still 1 after claim; after COMPLETE 1 → irq_id_o=1 again.
- COMPLETE with ID 0, 9 (NUM_SRC=8) or a non-in-service ID → no change in in_service or irq_o; rst asserted during an access → no ack, all state 0.
